// File: rtl/ir_uart_loader_if.sv
// Instruction-RAM write port driven by the serial program loader.
interface ir_uart_loader_if #(
   parameter int ADDR_W = 12
) ();
   logic [15:0]       m_data;
   logic [ADDR_W-1:0] m_addr;
   logic              m_wren;

   modport master (output m_data, output m_addr, output m_wren);
   modport slave  (input  m_data, input  m_addr, input  m_wren);
endinterface

// File: rtl/ir_uart_loader.sv
// Serial program loader: 8N1 UART receiver feeding a framed image into instruction RAM.
// Optional trailing XOR checksum byte and chk_err port when LOADER_CHECKSUM_EN is defined.
module ir_uart_loader #(
   parameter int CLKS_PER_BIT = 521,
   parameter int ADDR_W       = 12
) (
   input  logic             clock,
   input  logic             n_reset,
   input  logic             rxd,
   ir_uart_loader_if.master ram,
   output logic             loading,
   output logic             done,
   output logic             frame_err,
   output logic             len_err,
   output logic [ADDR_W:0]  words
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic             chk_err
`endif
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   WORD_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [3:0] {
      LD_WAIT_HDR, LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO,
      LD_WRITE, LD_CHK, LD_FIN
   } ld_state_t;

   logic              rx_meta_r, rx_sync_r, rx_prev_r;
   rx_state_t         rx_state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [2:0]        bit_idx_r;
   logic [7:0]        shift_r, rx_byte_r;
   logic              byte_valid_r, frame_evt_r, stop_wait_r;

   ld_state_t         ld_state_r;
   logic [7:0]        len_hi_r;
   logic [ADDR_W:0]   len_r, words_r;
   logic [ADDR_W-1:0] m_addr_r;
   logic [15:0]       m_data_r;
   logic              m_wren_r, loading_r, done_r, frame_err_r, len_err_r;
   logic [15:0]       len_s;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        chk_r;
   logic              chk_err_r;
`endif

   assign len_s      = {len_hi_r, rx_byte_r};
   assign ram.m_data = m_data_r;
   assign ram.m_addr = m_addr_r;
   assign ram.m_wren = m_wren_r;
   assign loading    = loading_r;
   assign done       = done_r;
   assign frame_err  = frame_err_r;
   assign len_err    = len_err_r;
   assign words      = words_r;
`ifdef LOADER_CHECKSUM_EN
   assign chk_err    = chk_err_r;
`endif

   // Synchronizer plus RX bit-timing FSM producing byte_valid / frame-error events.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         rx_meta_r    <= 1'b1;
         rx_sync_r    <= 1'b1;
         rx_prev_r    <= 1'b1;
         rx_state_r   <= RX_IDLE;
         cnt_r        <= '0;
         bit_idx_r    <= 3'd0;
         shift_r      <= 8'h00;
         rx_byte_r    <= 8'h00;
         byte_valid_r <= 1'b0;
         frame_evt_r  <= 1'b0;
         stop_wait_r  <= 1'b0;
      end else begin
         rx_meta_r    <= rxd;
         rx_sync_r    <= rx_meta_r;
         rx_prev_r    <= rx_sync_r;
         byte_valid_r <= 1'b0;
         frame_evt_r  <= 1'b0;
         case (rx_state_r)
            RX_IDLE: begin
               cnt_r <= '0;
               if (rx_prev_r && !rx_sync_r) begin
                  rx_state_r <= RX_START;
               end
            end
            RX_START: begin
               if (cnt_r == HALF_LAST) begin
                  cnt_r     <= '0;
                  bit_idx_r <= 3'd0;
                  rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            RX_DATA: begin
               if (cnt_r == BIT_LAST) begin
                  cnt_r     <= '0;
                  shift_r   <= {rx_sync_r, shift_r[7:1]};
                  bit_idx_r <= bit_idx_r + 3'd1;
                  if (bit_idx_r == 3'd7) begin
                     rx_state_r <= RX_STOP;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            RX_STOP: begin
               // After a bad stop bit, hold here until the line returns high.
               if (stop_wait_r) begin
                  if (rx_sync_r) begin
                     stop_wait_r <= 1'b0;
                     rx_state_r  <= RX_IDLE;
                  end
               end else if (cnt_r == BIT_LAST) begin
                  cnt_r <= '0;
                  if (rx_sync_r) begin
                     byte_valid_r <= 1'b1;
                     rx_byte_r    <= shift_r;
                     rx_state_r   <= RX_IDLE;
                  end else begin
                     frame_evt_r <= 1'b1;
                     stop_wait_r <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: rx_state_r <= RX_IDLE;
         endcase
      end
   end

   // Loader FSM: header, big-endian length, word assembly and RAM writes.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         ld_state_r  <= LD_WAIT_HDR;
         len_hi_r    <= 8'h00;
         len_r       <= '0;
         words_r     <= '0;
         m_addr_r    <= '0;
         m_data_r    <= 16'h0000;
         m_wren_r    <= 1'b0;
         loading_r   <= 1'b0;
         done_r      <= 1'b0;
         frame_err_r <= 1'b0;
         len_err_r   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk_r       <= 8'h00;
         chk_err_r   <= 1'b0;
`endif
      end else begin
         m_wren_r <= 1'b0;
         if (frame_evt_r && loading_r && ld_state_r != LD_WRITE) begin
            frame_err_r <= 1'b1;
            loading_r   <= 1'b0;
            ld_state_r  <= LD_WAIT_HDR;
         end else begin
            case (ld_state_r)
               LD_WAIT_HDR: begin
                  if (byte_valid_r && rx_byte_r == 8'hA5) begin
                     done_r      <= 1'b0;
                     frame_err_r <= 1'b0;
                     len_err_r   <= 1'b0;
                     words_r     <= '0;
                     m_addr_r    <= '0;
                     loading_r   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                     chk_r       <= 8'h00;
                     chk_err_r   <= 1'b0;
`endif
                     ld_state_r  <= LD_LEN_HI;
                  end
               end
               LD_LEN_HI: begin
                  if (byte_valid_r) begin
                     len_hi_r   <= rx_byte_r;
                     ld_state_r <= LD_LEN_LO;
                  end
               end
               LD_LEN_LO: begin
                  if (byte_valid_r) begin
                     if (len_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        ld_state_r <= LD_CHK;
`else
                        done_r     <= 1'b1;
                        loading_r  <= 1'b0;
                        ld_state_r <= LD_FIN;
`endif
                     end else if ({1'b0, len_s} > MAX_WORDS) begin
                        len_err_r  <= 1'b1;
                        loading_r  <= 1'b0;
                        ld_state_r <= LD_WAIT_HDR;
                     end else begin
                        len_r      <= len_s[ADDR_W:0];
                        ld_state_r <= LD_DATA_HI;
                     end
                  end
               end
               LD_DATA_HI: begin
                  if (byte_valid_r) begin
                     m_data_r[15:8] <= rx_byte_r;
`ifdef LOADER_CHECKSUM_EN
                     chk_r          <= chk_r ^ rx_byte_r;
`endif
                     ld_state_r     <= LD_DATA_LO;
                  end
               end
               LD_DATA_LO: begin
                  if (byte_valid_r) begin
                     m_data_r[7:0] <= rx_byte_r;
`ifdef LOADER_CHECKSUM_EN
                     chk_r         <= chk_r ^ rx_byte_r;
`endif
                     m_wren_r      <= 1'b1;
                     ld_state_r    <= LD_WRITE;
                  end
               end
               LD_WRITE: begin
                  // m_wren is high this cycle; address advances afterwards and may wrap on the last word.
                  m_addr_r <= m_addr_r + ADDR_ONE;
                  words_r  <= words_r + WORD_ONE;
                  if (words_r + WORD_ONE == len_r) begin
`ifdef LOADER_CHECKSUM_EN
                     ld_state_r <= LD_CHK;
`else
                     done_r     <= 1'b1;
                     loading_r  <= 1'b0;
                     ld_state_r <= LD_FIN;
`endif
                  end else begin
                     ld_state_r <= LD_DATA_HI;
                  end
               end
               LD_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                  if (byte_valid_r) begin
                     if (rx_byte_r == chk_r) begin
                        done_r    <= 1'b1;
                     end else begin
                        chk_err_r <= 1'b1;
                     end
                     loading_r  <= 1'b0;
                     ld_state_r <= LD_FIN;
                  end
`else
                  ld_state_r <= LD_WAIT_HDR;
`endif
               end
               LD_FIN:  ld_state_r <= LD_WAIT_HDR;
               default: ld_state_r <= LD_WAIT_HDR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ir_uart_loader.sv
// Directed self-checking bench for ir_uart_loader (short bit period, 16-word RAM).
module tb_ir_uart_loader;
   localparam int CPB = 16;
   localparam int AW  = 4;

   logic          clock = 1'b0;
   logic          n_reset;
   logic          rxd;
   logic          loading, done, frame_err, len_err;
   logic [AW:0]   words;
`ifdef LOADER_CHECKSUM_EN
   logic          chk_err;
`endif

   ir_uart_loader_if #(.ADDR_W(AW)) ram_if ();

   ir_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .clock     (clock),
      .n_reset   (n_reset),
      .rxd       (rxd),
      .ram       (ram_if.master),
      .loading   (loading),
      .done      (done),
      .frame_err (frame_err),
      .len_err   (len_err),
      .words     (words)
`ifdef LOADER_CHECKSUM_EN
      ,
      .chk_err   (chk_err)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_wren_cyc = 0;
   int done_rise_cyc = 0;
   logic done_q = 1'b0;
   logic [AW-1:0] wr_addr [$];
   logic [15:0]   wr_data [$];

   // Record every RAM write and the cycle of each done rising edge.
   always @(negedge clock) begin
      cyc    <= cyc + 1;
      done_q <= done;
      if (ram_if.m_wren === 1'b1) begin
         wr_addr.push_back(ram_if.m_addr);
         wr_data.push_back(ram_if.m_data);
         last_wren_cyc <= cyc;
      end
      if (done === 1'b1 && done_q === 1'b0) done_rise_cyc <= cyc;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clock);
      rxd = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clock);
      end
      rxd = stop_bit;
      repeat (CPB) @(negedge clock);
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge clock);
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      repeat (4) @(negedge clock);
      checks++;
      if ({ram_if.m_wren, loading, done, frame_err, len_err} !== 5'b00000 ||
          ram_if.m_data !== 16'h0000 || ram_if.m_addr !== 4'd0 || words !== 5'd0) begin
         errors++;
         $display("FAIL reset_outputs: got wren=%b load=%b done=%b fe=%b le=%b data=%h addr=%h words=%0d, want all 0",
                  ram_if.m_wren, loading, done, frame_err, len_err, ram_if.m_data, ram_if.m_addr, words);
      end
      n_reset = 1'b1;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_basic_load();
      logic [7:0] seq [7] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      clear_log();
      for (int i = 0; i < 7; i++) send_byte(seq[i], 1'b1);
      checks++;
      if (wr_addr.size() != 2) begin
         errors++; $display("FAIL basic_count: got %0d writes, want 2", wr_addr.size());
      end else begin
         checks++;
         if (wr_addr[0] !== 4'd0 || wr_data[0] !== 16'h1234) begin
            errors++; $display("FAIL basic_w0: got %h@%h, want 1234@0", wr_data[0], wr_addr[0]);
         end
         checks++;
         if (wr_addr[1] !== 4'd1 || wr_data[1] !== 16'hABCD) begin
            errors++; $display("FAIL basic_w1: got %h@%h, want abcd@1", wr_data[1], wr_addr[1]);
         end
      end
      checks++;
      if (words !== 5'd2 || done !== 1'b1 || loading !== 1'b0 || ram_if.m_addr !== 4'd2) begin
         errors++; $display("FAIL basic_status: got words=%0d done=%b loading=%b addr=%0d, want 2 1 0 2",
                            words, done, loading, ram_if.m_addr);
      end
      checks++;
      if (done_rise_cyc != last_wren_cyc + 1) begin
         errors++; $display("FAIL basic_done_timing: done rose at %0d, want %0d", done_rise_cyc, last_wren_cyc + 1);
      end
   endtask

   task automatic test_zero_len();
      clear_log();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'hA5, 1'b1);
      checks++;
      if (done !== 1'b0 || loading !== 1'b1) begin
         errors++; $display("FAIL zero_hdr: got done=%b loading=%b, want 0 1", done, loading);
      end
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      checks++;
      if (wr_addr.size() != 0 || done !== 1'b1 || words !== 5'd0 || loading !== 1'b0) begin
         errors++; $display("FAIL zero_end: got writes=%0d done=%b words=%0d loading=%b, want 0 1 0 0",
                            wr_addr.size(), done, words, loading);
      end
   endtask

   task automatic test_frame_err();
      logic [7:0] seq [5] = '{8'hA5, 8'h00, 8'h01, 8'h55, 8'h66};
      clear_log();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b0);
      checks++;
      if (frame_err !== 1'b1 || loading !== 1'b0 || done !== 1'b0 || wr_addr.size() != 0) begin
         errors++; $display("FAIL frame_abort: got fe=%b loading=%b done=%b writes=%0d, want 1 0 0 0",
                            frame_err, loading, done, wr_addr.size());
      end
      for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b1);
      checks++;
      if (frame_err !== 1'b0 || done !== 1'b1 || wr_addr.size() != 1) begin
         errors++; $display("FAIL frame_reload: got fe=%b done=%b writes=%0d, want 0 1 1",
                            frame_err, done, wr_addr.size());
      end else begin
         checks++;
         if (wr_addr[0] !== 4'd0 || wr_data[0] !== 16'h5566) begin
            errors++; $display("FAIL frame_reload_word: got %h@%h, want 5566@0", wr_data[0], wr_addr[0]);
         end
      end
   endtask

   task automatic test_length();
      int bad;
      clear_log();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1);
      checks++;
      if (len_err !== 1'b1 || loading !== 1'b0 || done !== 1'b0 || wr_addr.size() != 0) begin
         errors++; $display("FAIL len_over: got le=%b loading=%b done=%b writes=%0d, want 1 0 0 0",
                            len_err, loading, done, wr_addr.size());
      end
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      checks++;
      if (len_err !== 1'b0 || loading !== 1'b1) begin
         errors++; $display("FAIL len_max_accept: got le=%b loading=%b, want 0 1", len_err, loading);
      end
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i), 1'b1);
         send_byte(8'hA5 ^ 8'(i), 1'b1);
      end
      checks++;
      if (wr_addr.size() != 16) begin
         errors++; $display("FAIL len_max_count: got %0d writes, want 16", wr_addr.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 16; i++) begin
            if (wr_addr[i] !== 4'(i) || wr_data[i] !== {8'(i), 8'hA5 ^ 8'(i)}) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++; $display("FAIL len_max_data: got %0d bad words, want 0", bad);
         end
         checks++;
         if (wr_addr[15] !== 4'hF) begin
            errors++; $display("FAIL len_max_last_addr: got %h, want f", wr_addr[15]);
         end
      end
      checks++;
      if (words !== 5'd16 || done !== 1'b1 || loading !== 1'b0 || ram_if.m_addr !== 4'd0) begin
         errors++; $display("FAIL len_max_status: got words=%0d done=%b loading=%b addr=%0d, want 16 1 0 0",
                            words, done, loading, ram_if.m_addr);
      end
   endtask

   task automatic test_glitch();
      clear_log();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      @(negedge clock);
      rxd = 1'b0;
      repeat (CPB / 4) @(negedge clock);
      rxd = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      checks++;
      if (loading !== 1'b1 || wr_addr.size() != 0 || words !== 5'd0 || frame_err !== 1'b0) begin
         errors++; $display("FAIL glitch_ignored: got loading=%b writes=%0d words=%0d fe=%b, want 1 0 0 0",
                            loading, wr_addr.size(), words, frame_err);
      end
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      checks++;
      if (wr_addr.size() != 1 || done !== 1'b1) begin
         errors++; $display("FAIL glitch_after: got writes=%0d done=%b, want 1 1", wr_addr.size(), done);
      end else begin
         checks++;
         if (wr_data[0] !== 16'h1234 || wr_addr[0] !== 4'd0) begin
            errors++; $display("FAIL glitch_word: got %h@%h, want 1234@0", wr_data[0], wr_addr[0]);
         end
      end
   endtask

   task automatic test_reset_midload();
      logic [7:0] seq [5] = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h11};
      clear_log();
      for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b1);
      checks++;
      if (wr_addr.size() != 1 || words !== 5'd1 || loading !== 1'b1) begin
         errors++; $display("FAIL midload_pre: got writes=%0d words=%0d loading=%b, want 1 1 1",
                            wr_addr.size(), words, loading);
      end
      n_reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({ram_if.m_wren, loading, done, frame_err, len_err} !== 5'b00000 ||
          ram_if.m_addr !== 4'd0 || words !== 5'd0 || ram_if.m_data !== 16'h0000) begin
         errors++; $display("FAIL midload_reset: got loading=%b done=%b addr=%0d words=%0d data=%h, want all 0",
                            loading, done, ram_if.m_addr, words, ram_if.m_data);
      end
      n_reset = 1'b1;
      send_byte(8'h22, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h33, 1'b1);
      checks++;
      if (wr_addr.size() != 1 || words !== 5'd0 || loading !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL midload_after: got writes=%0d words=%0d loading=%b done=%b, want 1 0 0 0",
                            wr_addr.size(), words, loading, done);
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] seq [5] = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
      for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b1);
      send_byte(8'h26, 1'b1);
      checks++;
      if (done !== 1'b1 || chk_err !== 1'b0 || loading !== 1'b0) begin
         errors++; $display("FAIL chk_good: got done=%b chk_err=%b loading=%b, want 1 0 0", done, chk_err, loading);
      end
      for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b1);
      send_byte(8'h27, 1'b1);
      checks++;
      if (done !== 1'b0 || chk_err !== 1'b1 || loading !== 1'b0) begin
         errors++; $display("FAIL chk_bad: got done=%b chk_err=%b loading=%b, want 0 1 0", done, chk_err, loading);
      end
   endtask
`endif

   initial begin
      rxd     = 1'b1;
      n_reset = 1'b0;
      test_reset();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`else
      test_basic_load();
      test_zero_len();
      test_frame_err();
      test_length();
      test_glitch();
      test_reset_midload();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
